// File: rtl/dircc_send_handler_if.sv
// Packet stream between the send handler (master) and the router (slave).
interface dircc_send_handler_if;
    logic [63:0] packet_out;
    logic        packet_out_valid;
    logic        packet_out_ready;
    logic [7:0]  dest_index;

    modport master (
        output packet_out,
        output packet_out_valid,
        output dest_index,
        input  packet_out_ready
    );

    modport slave (
        input  packet_out,
        input  packet_out_valid,
        input  dest_index,
        output packet_out_ready
    );
endinterface

// File: rtl/dircc_send_handler.sv
// Transmit-side device handler: emits one tick packet per outgoing edge, then writes back count+1 / sent.
// Optional stall timeout with send_error output when DIRCC_SEND_TIMEOUT_EN is defined.
module dircc_send_handler #(
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int MAX_FANOUT        = 4,
    parameter int COUNT_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES    = 256,
    localparam int FANOUT_WIDTH     = $clog2(MAX_FANOUT + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDRESS_MEM_WIDTH-1:0] address,
    input  logic                         send_req,
    input  logic [FANOUT_WIDTH-1:0]      fanout,
    input  logic [COUNT_WIDTH-1:0]       read_count,
    input  logic                         read_sent,
    dircc_send_handler_if.master         pkt_if,
    output logic                         busy,
    output logic [COUNT_WIDTH-1:0]       write_count,
    output logic                         write_sent,
    output logic                         write_state_valid,
    output logic                         send_done
`ifdef DIRCC_SEND_TIMEOUT_EN
    ,
    output logic                         send_error
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [15:0]             addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [FANOUT_WIDTH-1:0] fanout_q, fanout_d;
    logic [7:0]              edge_q, edge_d;
    logic                    valid_q, valid_d;
    logic [COUNT_WIDTH-1:0]  wcount_q, wcount_d;
    logic                    wsent_q, wsent_d;
    logic                    wsv_q, wsv_d;
    logic                    done_q, done_d;

    // Only the low 16 bits of address and count travel in the packet.
    logic [ADDRESS_MEM_WIDTH+15:0] addr_ext;
    logic [COUNT_WIDTH+15:0]       count_ext;
    logic [COUNT_WIDTH-1:0]        count_sat;
    logic                          last_edge;
    logic                          unused_bits;

    assign addr_ext  = {16'b0, address};
    assign count_ext = {16'b0, count_q};
    assign count_sat = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q : count_q + COUNT_WIDTH'(1);
    assign last_edge = (edge_q == 8'(fanout_q) - 8'd1);
    assign unused_bits = read_sent ^ (^addr_ext[ADDRESS_MEM_WIDTH+15:16])
                       ^ (^count_ext[COUNT_WIDTH+15:16]) ^ (TIMEOUT_CYCLES == 0);

`ifdef DIRCC_SEND_TIMEOUT_EN
    localparam int STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic                   err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        fanout_d = fanout_q;
        edge_d   = edge_q;
        valid_d  = valid_q;
        wcount_d = wcount_q;
        wsent_d  = wsent_q;
        wsv_d    = 1'b0;
        done_d   = 1'b0;
`ifdef DIRCC_SEND_TIMEOUT_EN
        stall_d  = stall_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (send_req) begin
                    addr_d   = addr_ext[15:0];
                    count_d  = read_count;
                    fanout_d = (fanout > FANOUT_WIDTH'(MAX_FANOUT)) ? FANOUT_WIDTH'(MAX_FANOUT) : fanout;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                edge_d = 8'd0;
`ifdef DIRCC_SEND_TIMEOUT_EN
                stall_d = '0;
`endif
                if (fanout_q == '0) begin
                    state_d  = ST_UPDATE;
                    wcount_d = count_sat;
                    wsent_d  = 1'b1;
                    wsv_d    = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d = ST_SEND;
                    valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (valid_q && pkt_if.packet_out_ready) begin
                    edge_d = edge_q + 8'd1;
`ifdef DIRCC_SEND_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (last_edge) begin
                        valid_d  = 1'b0;
                        state_d  = ST_UPDATE;
                        wcount_d = count_sat;
                        wsent_d  = 1'b1;
                        wsv_d    = 1'b1;
                        done_d   = 1'b1;
                    end
                end
`ifdef DIRCC_SEND_TIMEOUT_EN
                // Abandon the burst without touching device state.
                else if (valid_q) begin
                    if (stall_q == STALL_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        valid_d = 1'b0;
                        state_d = ST_UPDATE;
                        err_d   = 1'b1;
                    end else begin
                        stall_d = stall_q + STALL_WIDTH'(1);
                    end
                end
`endif
            end
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            fanout_q <= '0;
            edge_q   <= '0;
            valid_q  <= 1'b0;
            wcount_q <= '0;
            wsent_q  <= 1'b0;
            wsv_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef DIRCC_SEND_TIMEOUT_EN
            stall_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            fanout_q <= fanout_d;
            edge_q   <= edge_d;
            valid_q  <= valid_d;
            wcount_q <= wcount_d;
            wsent_q  <= wsent_d;
            wsv_q    <= wsv_d;
            done_q   <= done_d;
`ifdef DIRCC_SEND_TIMEOUT_EN
            stall_q  <= stall_d;
            err_q    <= err_d;
`endif
        end
    end

    assign pkt_if.packet_out       = {addr_q, count_ext[15:0], edge_q, 24'h0};
    assign pkt_if.packet_out_valid = valid_q;
    assign pkt_if.dest_index       = edge_q;
    assign busy                    = (state_q != ST_IDLE);
    assign write_count             = wcount_q;
    assign write_sent              = wsent_q;
    assign write_state_valid       = wsv_q;
    assign send_done               = done_q;
`ifdef DIRCC_SEND_TIMEOUT_EN
    assign send_error              = err_q;
`endif

endmodule

// File: tb/tb_dircc_send_handler.sv
// Bench for dircc_send_handler: vector table, randomized transactions against a transaction-level model,
// stall/reset sequences, and the stall timeout when DIRCC_SEND_TIMEOUT_EN is defined.
module tb_dircc_send_handler;
    localparam int AW = 32;
    localparam int MF = 4;
    localparam int CW = 16;
    localparam int TO = 8;
    localparam int FW = $clog2(MF + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic          send_req = 1'b0;
    logic [FW-1:0] fanout = '0;
    logic [CW-1:0] read_count = '0;
    logic          read_sent = 1'b0;
    logic          ready = 1'b0;
    logic          busy;
    logic [CW-1:0] write_count;
    logic          write_sent;
    logic          write_state_valid;
    logic          send_done;
`ifdef DIRCC_SEND_TIMEOUT_EN
    logic          send_error;
`endif

    always #5 clk = ~clk;

    dircc_send_handler_if pkt_if ();
    assign pkt_if.packet_out_ready = ready;

    dircc_send_handler #(
        .ADDRESS_MEM_WIDTH(AW), .MAX_FANOUT(MF), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .send_req(send_req),
        .fanout(fanout), .read_count(read_count), .read_sent(read_sent),
        .pkt_if(pkt_if), .busy(busy), .write_count(write_count), .write_sent(write_sent),
        .write_state_valid(write_state_valid), .send_done(send_done)
`ifdef DIRCC_SEND_TIMEOUT_EN
        , .send_error(send_error)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: record accepted packets and write-backs, check stall stability.
    logic [63:0]   acc_q[$];
    logic [7:0]    dest_q[$];
    logic [CW:0]   wb_q[$];
    int            stall_cnt = 0;
    int            err_cnt = 0;
    logic [63:0]   prev_pkt = '0;
    logic          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && pkt_if.packet_out_valid)
                chk("stall_hold", pkt_if.packet_out, prev_pkt);
            if (pkt_if.packet_out_valid && ready) begin
                acc_q.push_back(pkt_if.packet_out);
                dest_q.push_back(pkt_if.dest_index);
            end
            if (pkt_if.packet_out_valid && !ready) stall_cnt++;
            prev_stall = pkt_if.packet_out_valid && !ready;
            prev_pkt   = pkt_if.packet_out;
            if (write_state_valid) begin
                wb_q.push_back({write_sent, write_count});
                chk("done_with_wsv", 64'(send_done), 64'd1);
            end else begin
                chk("done_without_wsv", 64'(send_done), 64'd0);
            end
`ifdef DIRCC_SEND_TIMEOUT_EN
            if (send_error) err_cnt++;
`endif
        end
    end

    // mode 0: ready always high; 1: random ready and stray requests; 2: stall first packet stall_n cycles.
    task automatic run_txn(input string tag, input logic [AW-1:0] a, input int fo, input logic [CW-1:0] c,
                           input int mode, input int stall_n, input int exp_np, input logic [CW-1:0] exp_wc,
                           input int exp_lat);
        int fc, lat, first_v;
        bit done;
        logic [63:0] ep;
        fc = (fo > MF) ? MF : fo;
        acc_q.delete(); dest_q.delete(); wb_q.delete();
        stall_cnt = 0;
        address = a; fanout = FW'(fo); read_count = c; read_sent = 1'($urandom_range(0, 1));
        send_req = 1'b1; ready = (mode == 0);
        @(posedge clk); #1;
        send_req = 1'b0;
        address = $urandom(); fanout = FW'($urandom_range(0, 7)); read_count = CW'($urandom());
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 1; first_v = -1; done = 0;
        while (!done && lat < 300) begin
            if (pkt_if.packet_out_valid && first_v < 0) first_v = lat;
            if (send_done) done = 1;
            else begin
                if (mode == 1) begin
                    ready    = ($urandom_range(0, 3) != 0);
                    send_req = ($urandom_range(0, 3) == 0);
                end else if (mode == 2) begin
                    ready = (stall_cnt >= stall_n);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        send_req = 1'b0;
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_wcount"}, 64'(write_count), 64'(exp_wc));
        chk({tag, "_wsent"}, 64'(write_sent), 64'd1);
        if (mode == 0) begin
            chk({tag, "_done_lat"}, 64'(lat), 64'(exp_lat));
            chk({tag, "_first_valid"}, 64'(first_v), 64'((fc > 0) ? 2 : -1));
        end
        if (mode == 2) chk({tag, "_stalls"}, 64'(stall_cnt), 64'(stall_n));
        chk({tag, "_npkts"}, 64'(acc_q.size()), 64'(exp_np));
        for (int i = 0; i < acc_q.size() && i < exp_np; i++) begin
            ep = {a[15:0], c[15:0], 8'(i), 24'h0};
            chk({tag, "_pkt"}, acc_q[i], ep);
            chk({tag, "_dest"}, 64'(dest_q[i]), 64'(i));
        end
        @(posedge clk); #1;
        chk({tag, "_nwb"}, 64'(wb_q.size()), 64'd1);
        if (wb_q.size() > 0) chk({tag, "_wb"}, 64'(wb_q[0]), 64'({1'b1, exp_wc}));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_wsv_low"}, 64'(write_state_valid), 64'd0);
        chk({tag, "_wcount_hold"}, 64'(write_count), 64'(exp_wc));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            fo;
        logic [CW-1:0] cnt;
        int            np;
        logic [CW-1:0] wc;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fo;
        logic [CW-1:0] c, wc;
        logic [AW-1:0] a;
        vecs[0] = '{32'h0000_0012, 3, 16'h0005, 3, 16'h0006, 5};
        vecs[1] = '{32'hABCD_1234, 0, 16'h0007, 0, 16'h0008, 2};
        vecs[2] = '{32'h0000_FFFF, 1, 16'hFFFF, 1, 16'hFFFF, 3};
        vecs[3] = '{32'h0000_5A5A, 7, 16'hFFFE, 4, 16'hFFFF, 6};
        vecs[4] = '{32'h0000_0001, 4, 16'h0000, 4, 16'h0001, 6};
        vecs[5] = '{32'hDEAD_BEEF, 2, 16'h8000, 2, 16'h8001, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(pkt_if.packet_out_valid), 64'd0);
        chk("rst_packet", pkt_if.packet_out, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wsv", 64'(write_state_valid), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].fo, vecs[i].cnt, 0, 0,
                    vecs[i].np, vecs[i].wc, vecs[i].lat);

        run_txn("stall4", 32'h0000_0042, 2, 16'h0010, 2, 4, 2, 16'h0011, 0);

        for (int t = 0; t < 30; t++) begin
            a  = $urandom();
            fo = $urandom_range(0, 7);
            c  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : CW'($urandom());
            wc = (c == 16'hFFFF) ? c : c + 16'd1;
            run_txn($sformatf("rnd%0d", t), a, fo, c, 1, 0, (fo > MF) ? MF : fo, wc, 0);
        end

        // Reset during SEND with a stray request while busy.
        wb_q.delete();
        address = 32'h0000_0033; fanout = FW'(4); read_count = 16'h0009; ready = 1'b0; send_req = 1'b1;
        @(posedge clk); #1; send_req = 1'b0;
        @(posedge clk); #1; send_req = 1'b1;
        @(posedge clk); #1; send_req = 1'b0;
        chk("mid_valid", 64'(pkt_if.packet_out_valid), 64'd1);
        chk("mid_packet", pkt_if.packet_out, {16'h0033, 16'h0009, 8'd0, 24'h0});
        reset_n = 1'b0;
        #1;
        chk("rst2_valid", 64'(pkt_if.packet_out_valid), 64'd0);
        chk("rst2_packet", pkt_if.packet_out, 64'd0);
        chk("rst2_dest", 64'(pkt_if.dest_index), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_wcount", 64'(write_count), 64'd0);
        chk("rst2_wsent", 64'(write_sent), 64'd0);
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2_no_wb", 64'(wb_q.size()), 64'd0);
        chk("rst2_idle", 64'(busy), 64'd0);
        chk("rst2_valid_after", 64'(pkt_if.packet_out_valid), 64'd0);

`ifdef DIRCC_SEND_TIMEOUT_EN
        begin
            int n;
            bit seen;
            acc_q.delete(); wb_q.delete(); stall_cnt = 0; err_cnt = 0; ready = 1'b0;
            address = 32'h0000_0077; fanout = FW'(2); read_count = 16'h0003; send_req = 1'b1;
            @(posedge clk); #1; send_req = 1'b0;
            n = 0; seen = 0;
            while (n < 60 && !(seen && !pkt_if.packet_out_valid)) begin
                if (pkt_if.packet_out_valid) seen = 1;
                @(posedge clk); #1;
                n++;
            end
            chk("to_valid_dropped", 64'(seen && !pkt_if.packet_out_valid), 64'd1);
            chk("to_stalls", 64'(stall_cnt), 64'(TO));
            repeat (3) @(posedge clk);
            #1;
            chk("to_err_pulses", 64'(err_cnt), 64'd1);
            chk("to_no_wb", 64'(wb_q.size()), 64'd0);
            chk("to_no_accepts", 64'(acc_q.size()), 64'd0);
            chk("to_idle", 64'(busy), 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
